// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART receiver and the matching transmitter.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int MID_TICK   = 8;

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, byte out with valid/ack handshake and status pulses.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ack;
    logic                 framing_error;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  rx,
        input  data_ack,
        output data_out,
        output data_valid,
        output framing_error,
        output overrun,
        output busy
    );

    modport slave (
        output rx,
        output data_ack,
        input  data_out,
        input  data_valid,
        input  framing_error,
        input  overrun,
        input  busy
    );

endinterface

// File: rtl/uart_sample_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, restartable by a synchronous clear.
module uart_sample_tick #(
    parameter int DIV = 27
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    output logic o_tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset_n || i_clear) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tick = (r_count == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, one-deep output register, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clockfreq = 50000000,
    parameter int boudrate  = 115200
) (
    input  logic      clock,
    input  logic      reset_n,
    uart_rx_if.master bus
);
    localparam int DIV   = clockfreq / (boudrate * OVERSAMPLE);
    localparam int SUB_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(MID_TICK - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic [1:0]           r_sync;
    rx_state_t            r_state, w_state_next;
    logic [SUB_W-1:0]     r_sub, w_sub_next;
    logic [BIT_W-1:0]     r_bit, w_bit_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [DATA_BITS-1:0] r_data, w_data_next;
    logic                 r_valid, w_valid_next;
    logic                 r_fe, w_fe_next;
    logic                 r_ovr, w_ovr_next;
    logic                 w_rx_s;
    logic                 w_tick;
    logic                 w_tick_clear;

    assign w_rx_s       = r_sync[1];
    // Holding the divider in reset while idle aligns every sample point to the detected start edge.
    assign w_tick_clear = (r_state == IDLE) || (r_state == WAIT_HIGH);

    uart_sample_tick #(
        .DIV(DIV)
    ) u_tick (
        .clock  (clock),
        .reset_n(reset_n),
        .i_clear(w_tick_clear),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        w_sub_next   = r_sub;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_data_next  = r_data;
        w_valid_next = r_valid && !bus.data_ack;
        w_fe_next    = 1'b0;
        w_ovr_next   = 1'b0;
        case (r_state)
            WAIT_HIGH: begin
                if (w_rx_s) w_state_next = IDLE;
            end
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = START;
                    w_sub_next   = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_sub == SUB_MID) begin
                        w_sub_next = '0;
                        if (!w_rx_s) begin
                            w_state_next = DATA;
                            w_bit_next   = '0;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_sub_next = r_sub + 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_sub == SUB_LAST) begin
                        w_sub_next   = '0;
                        w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit == BIT_LAST) w_state_next = STOP;
                        else                   w_bit_next   = r_bit + 1'b1;
                    end else begin
                        w_sub_next = r_sub + 1'b1;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_sub == SUB_LAST) begin
                        w_sub_next = '0;
                        if (w_rx_s) begin
                            // Return straight to IDLE mid stop bit so back-to-back frames are caught.
                            w_data_next  = r_shift;
                            w_valid_next = 1'b1;
                            w_ovr_next   = r_valid && !bus.data_ack;
                            w_state_next = IDLE;
                        end else begin
                            w_fe_next    = 1'b1;
                            w_state_next = WAIT_HIGH;
                        end
                    end else begin
                        w_sub_next = r_sub + 1'b1;
                    end
                end
            end
            default: w_state_next = WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync  <= 2'b11;
            r_state <= WAIT_HIGH;
            r_sub   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_fe    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], bus.rx};
            r_state <= w_state_next;
            r_sub   <= w_sub_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
            r_fe    <= w_fe_next;
            r_ovr   <= w_ovr_next;
        end
    end

    assign bus.data_out      = r_data;
    assign bus.data_valid    = r_valid;
    assign bus.framing_error = r_fe;
    assign bus.overrun       = r_ovr;
    assign bus.busy          = (r_state == START) || (r_state == DATA) || (r_state == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a queue-based byte model of the UART receiver.
module tb_uart_rx;

    localparam int CLK_HZ  = 50000000;
    localparam int BAUD    = 115200;
    localparam int TB_DIV  = CLK_HZ / (BAUD * 16);
    localparam int P_NOM   = 434;
    localparam int LATENCY = 2 + 152 * TB_DIV + 1;

    logic clock;
    logic reset_n;

    uart_rx_if bus ();

    uart_rx #(
        .clockfreq(CLK_HZ),
        .boudrate (BAUD)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_ovr = 0;
    int n_fe  = 0;
    int t_low = 0;
    int last_rise = -1;
    int ack_at  = -1;
    int probe_a = -1;
    int probe_b = -1;
    logic rise_busy, rise_prev_busy, prev_dv, prev_busy;
    logic probe_a_busy, probe_b_busy;
    bit auto_ack = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: sample DUT state on the falling edge, then drive the ack for the next rising edge.
    task automatic step();
        @(negedge clock);
        cyc++;
        if (bus.overrun === 1'b1) n_ovr++;
        if (bus.framing_error === 1'b1) n_fe++;
        if (bus.data_valid === 1'b1 && prev_dv !== 1'b1) begin
            last_rise      = cyc;
            rise_busy      = bus.busy;
            rise_prev_busy = prev_busy;
        end
        if (cyc == probe_a) probe_a_busy = bus.busy;
        if (cyc == probe_b) probe_b_busy = bus.busy;
        prev_dv   = bus.data_valid;
        prev_busy = bus.busy;
        if (auto_ack && bus.data_valid === 1'b1 && bus.data_ack !== 1'b1) begin
            got.push_back(bus.data_out);
            bus.data_ack = 1'b1;
        end else begin
            bus.data_ack = (cyc == ack_at);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int p, input bit stop_val);
        $display("frame data=%02h clocks_per_bit=%0d stop=%0d", b, p, stop_val);
        t_low  = cyc;
        bus.rx = 1'b0;
        repeat (p) step();
        for (int k = 0; k < 8; k++) begin
            bus.rx = b[k];
            repeat (p) step();
        end
        bus.rx = stop_val;
        repeat (p) step();
    endtask

    task automatic ack_pending();
        ack_at = cyc + 1;
        step();
        step();
    endtask

    task automatic check_stream(input string tag);
        logic [7:0] g;
        chk({tag, "_count"}, got.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            g = (got.size() > 0) ? got.pop_front() : 8'hxx;
            chk({tag, "_byte"}, g, exp_q.pop_front());
        end
        got.delete();
    endtask

    initial begin
        logic [7:0] rb;
        int rp;
        bus.rx = 1'b1;
        bus.data_ack = 1'b0;
        reset_n = 1'b0;
        repeat (3) step();
        chk("rst_data_out", bus.data_out, 8'h00);
        chk("rst_data_valid", bus.data_valid, 1'b0);
        chk("rst_framing_error", bus.framing_error, 1'b0);
        chk("rst_overrun", bus.overrun, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        reset_n = 1'b1;
        repeat (10) step();

        // Basic frame, exact completion cycle
        last_rise = -1;
        n_fe = 0;
        send_byte(8'hA5, P_NOM, 1'b1);
        repeat (5) step();
        chk("basic_data", bus.data_out, 8'hA5);
        chk("basic_valid", bus.data_valid, 1'b1);
        chk("basic_latency", last_rise - t_low, LATENCY);
        chk("basic_busy_at_valid", rise_busy, 1'b0);
        chk("basic_busy_before_valid", rise_prev_busy, 1'b1);
        chk("basic_no_fe", n_fe, 0);

        // Back-to-back with prompt ack
        ack_pending();
        chk("ack_clears_valid", bus.data_valid, 1'b0);
        got.delete();
        n_ovr = 0;
        auto_ack = 1;
        exp_q.push_back(8'h00); send_byte(8'h00, P_NOM, 1'b1);
        exp_q.push_back(8'hFF); send_byte(8'hFF, P_NOM, 1'b1);
        exp_q.push_back(8'h55); send_byte(8'h55, P_NOM, 1'b1);
        repeat (20) step();
        check_stream("b2b");
        chk("b2b_no_overrun", n_ovr, 0);

        // Overrun, then completion coinciding with ack
        auto_ack = 0;
        n_ovr = 0;
        send_byte(8'h12, P_NOM, 1'b1);
        send_byte(8'h34, P_NOM, 1'b1);
        repeat (5) step();
        chk("ovr_pulses", n_ovr, 1);
        chk("ovr_data", bus.data_out, 8'h34);
        chk("ovr_valid", bus.data_valid, 1'b1);
        n_ovr = 0;
        ack_at = cyc + 2 + 152 * TB_DIV;
        send_byte(8'h56, P_NOM, 1'b1);
        repeat (5) step();
        chk("ackcoin_no_overrun", n_ovr, 0);
        chk("ackcoin_data", bus.data_out, 8'h56);
        chk("ackcoin_valid", bus.data_valid, 1'b1);

        // Framing error followed by a break
        n_fe = 0;
        send_byte(8'h3C, P_NOM, 1'b0);
        repeat (20 * P_NOM) step();
        chk("fe_pulses", n_fe, 1);
        chk("fe_valid_kept", bus.data_valid, 1'b1);
        chk("fe_data_kept", bus.data_out, 8'h56);
        chk("break_not_busy", bus.busy, 1'b0);
        bus.rx = 1'b1;
        repeat (50) step();
        ack_pending();
        got.delete();
        auto_ack = 1;
        exp_q.push_back(8'h81);
        send_byte(8'h81, P_NOM, 1'b1);
        repeat (20) step();
        check_stream("after_break");

        // Glitch shorter than half a bit
        n_fe = 0;
        probe_a = cyc + 2 + 8 * TB_DIV;
        probe_b = probe_a + 1;
        $display("glitch low for 100 clocks");
        bus.rx = 1'b0;
        repeat (100) step();
        bus.rx = 1'b1;
        repeat (300) step();
        chk("glitch_busy_at_tick8", probe_a_busy, 1'b1);
        chk("glitch_idle_after_tick8", probe_b_busy, 1'b0);
        chk("glitch_no_output", got.size(), 0);
        chk("glitch_no_fe", n_fe, 0);

        // Random bytes at rates within +/-3 percent
        for (int i = 0; i < 2; i++) begin
            rb = 8'($urandom);
            rp = $urandom_range(421, 447);
            exp_q.push_back(rb);
            send_byte(rb, rp, 1'b1);
        end
        repeat (20) step();
        check_stream("rand");
        auto_ack = 0;
        rb = 8'($urandom);
        rp = $urandom_range(421, 447);
        send_byte(rb, rp, 1'b1);
        repeat (20) step();
        chk("rand_pending_data", bus.data_out, rb);
        chk("rand_pending_valid", bus.data_valid, 1'b1);

        // Reset pulse during bit 4 of 0xC3
        rb = 8'hC3;
        $display("frame data=%02h with reset during bit 4", rb);
        bus.rx = 1'b0;
        repeat (P_NOM) step();
        for (int k = 0; k < 4; k++) begin
            bus.rx = rb[k];
            repeat (P_NOM) step();
        end
        bus.rx = rb[4];
        repeat (200) step();
        reset_n = 1'b0;
        step();
        chk("midrst_data_out", bus.data_out, 8'h00);
        chk("midrst_valid", bus.data_valid, 1'b0);
        chk("midrst_fe", bus.framing_error, 1'b0);
        chk("midrst_ovr", bus.overrun, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        reset_n = 1'b1;
        repeat (P_NOM - 200) step();
        for (int k = 5; k < 8; k++) begin
            bus.rx = rb[k];
            repeat (P_NOM) step();
        end
        bus.rx = 1'b1;
        repeat (P_NOM) step();
        repeat (2500) step();
        ack_pending();
        got.delete();
        n_ovr = 0;
        auto_ack = 1;
        exp_q.push_back(8'h7E);
        send_byte(8'h7E, P_NOM, 1'b1);
        repeat (20) step();
        check_stream("after_reset");
        chk("after_reset_no_overrun", n_ovr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: 8N1 frames, LSB first, sampled with 16× oversampling from a divider derived from the system clock. It sits between the external RX pin and the processor's I/O path and delivers each received byte in a one-deep output register with a valid/ack handshake. It also reports framing errors and overruns.

## Interface
- `clockfreq`, 50000000: system clock frequency in Hz.
- `boudrate`, 115200: line bit rate.
- `OVERSAMPLE`, 16: sample ticks per bit. Fixed; must not be overridden.
- `DIV`, clockfreq/(boudrate*OVERSAMPLE), integer floor, 27 at defaults: clocks per sample tick. Must be ≥ 2.
- `clock` in 1: system clock; all logic is on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `rx` in 1: asynchronous serial input; idles high.
- `data_out` out 8: last good byte; reset value 0.
- `data_valid` out 1: byte pending in `data_out`; reset value 0.
- `data_ack` in 1: consumer accepts the pending byte.
- `framing_error` out 1: one-cycle pulse; reset value 0.
- `overrun` out 1: one-cycle pulse; reset value 0.
- `busy` out 1: high while the FSM is not in IDLE or WAIT_HIGH; reset value 0.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer to `rx_s`. Both flops reset to 1.
- **Tick counter.**
  - Counts 0..DIV-1 and asserts `tick` when the count is DIV-1.
  - Is held at 0 in IDLE and WAIT_HIGH, so the sample phase aligns to the start edge.
- **FSM states:** WAIT_HIGH, IDLE, START, DATA, STOP. The reset state is WAIT_HIGH.
- **WAIT_HIGH:** go to IDLE when `rx_s`=1.
- **IDLE:** `rx_s`=0 moves to START with tick count 0 and sub-tick count 0.
- **START:** on the 8th tick (mid start bit), sample `rx_s`.
  - If 0, go to DATA with bit index 0.
  - If 1, it is a false start: go to IDLE with no output.
- **DATA:**
  - Every 16th tick, shift `rx_s` into the shift register, LSB first.
  - After bit 7, go to STOP.
- **STOP:** on the 16th tick (mid stop bit), sample `rx_s`.
  - If 1: load `data_out`, set `data_valid`, go to IDLE. No wait for the end of the stop bit, so back-to-back frames work.
  - If 0: pulse `framing_error`, leave `data_out`/`data_valid` unchanged, go to WAIT_HIGH. A break condition therefore does not retrigger.
- **Handshake:**
  - `data_valid` clears in the cycle after `data_ack`=1 while `data_valid`=1.
  - `data_ack` with `data_valid`=0 is ignored.
- **Overrun:** a good byte that completes while `data_valid`=1 and `data_ack`=0:
  - overwrites `data_out`;
  - leaves `data_valid` at 1;
  - pulses `overrun` for one cycle.
- **Simultaneous ack and completion:** the new byte loads, `data_valid` stays 1, and there is no overrun.
- **Reset mid-frame:**
  - All outputs go to their reset values and the FSM goes to WAIT_HIGH.
  - The partial byte is discarded.

## Timing
- **Pin to `rx_s`:** 2 cycles.
- **Tick times:** let E be the first cycle with `rx_s`=0 in IDLE. Tick n occurs at cycle E + n·DIV.
- **Sample points:**
  - start bit at tick 8;
  - data bit k at tick 24+16k;
  - stop bit at tick 152.
- **Output timing:** `data_valid` (or `framing_error`) is registered high at E+152·DIV+1. At defaults this is E+4105.
- **Pulse width:** `framing_error` and `overrun` are high for exactly one cycle.
- **Re-arm:** the FSM is in IDLE at E+152·DIV+1 after a good frame, so a start edge seen in that cycle is accepted.
- **Rate tolerance:** a ±3% rate mismatch must still receive correctly. The sampling offset stays within ±5 sub-ticks over 10 bits.

## Structure
- **Package `uart_pkg`:**
  - FSM state enum: WAIT_HIGH, IDLE, START, DATA, STOP;
  - OVERSAMPLE = 16;
  - frame data width = 8;
  - mid-bit sub-tick = 8.
- **Sub-module `uart_sample_tick`:**
  - Parameterized by DIV; synchronous clear input; one-cycle `tick` output.
  - Counter width is ceil(log2(DIV)).
  - Reusable by the matching transmitter.
- **Top `uart_rx`:** synchronizer, FSM, sub-tick and bit counters, shift register, output register and flags. Target 150–250 lines.

## Test plan
- **Basic frame:** send 0xA5 at 115200 bit/s (434 clocks/bit) with no ack → `data_out`=0xA5 and `data_valid`=1 at the specified cycle; `framing_error`=0; `busy` drops in the same cycle.
- **Back-to-back frames:** send 0x00, 0xFF, 0x55 back-to-back, acking each one cycle after valid → three bytes received in order, no overrun.
- **Overrun:** send 0x12, then 0x34 without ack → `overrun` pulses once, `data_out`=0x34, `data_valid` stays 1. Repeat with `data_ack` asserted in the completion cycle → no overrun.
- **Framing error / break:** send 0x3C with the stop bit forced 0, then hold `rx` low for 20 bit times → one `framing_error` pulse, `data_valid` unchanged, no further activity until `rx` returns high; the next frame 0x81 is received correctly.
- **Glitch rejection:** a 3-bit-time-wide... specifically, drive `rx` low for 100 clocks (shorter than half a bit), then high → no output, FSM back in IDLE at tick 8.
- **Reset mid-frame:** assert `reset_n`=0 for 1 cycle during bit 4 of 0xC3 → all outputs 0 and `busy`=0. The remainder of the frame is ignored until the line is high. The next frame, 0x7E, is received correctly.
